id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Consumes the two read-port values and selects the final operands, priority EX > MEM > register file; the register file already handles write-back forwarding.
- Detects load-use hazards and inserts bubbles.
- Latches operands and control into the ID/EX register under a valid/ready handshake, with flush.

---
 rtl/id_ex_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand forwarding (EX > MEM > RF), load-use bubbles, handshaked ID/EX register.
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;

  logic              ex_fwd_ok;
  logic              lu;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  // A load in EX has no result yet, so only non-load producers forward from EX
  assign ex_fwd_ok = ex_valid_q & ex_reg_write_q & ~ex_mem_read_q;

  assign lu = id_valid & ex_valid_q & ex_mem_read_q & ex_reg_write_q & (ex_rd_q != 5'd0) &
              ((id_use_rs & (ex_rd_q == id_rs)) | (id_use_rt & (ex_rd_q == id_rt)));

  assign id_ready = ex_ready & ~lu;

  always_comb begin
    fwd_a = rf_a;
    if (id_rs == 5'd0) begin
      fwd_a = '0;
    end else if (ex_fwd_ok && (ex_rd_q == id_rs)) begin
      fwd_a = ex_result;
    end else if (mem_reg_write && (mem_rd == id_rs)) begin
      fwd_a = mem_result;
    end else begin
      fwd_a = rf_a;
    end
  end

  always_comb begin
    fwd_b = rf_b;
    if (id_rt == 5'd0) begin
      fwd_b = '0;
    end else if (ex_fwd_ok && (ex_rd_q == id_rt)) begin
      fwd_b = ex_result;
    end else if (mem_reg_write && (mem_rd == id_rt)) begin
      fwd_b = mem_result;
    end else begin
      fwd_b = rf_b;
    end
  end

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_a_d         = ex_a_q;
    ex_b_d         = ex_b_q;
    ex_imm_d       = ex_imm_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_ctrl_d      = ex_ctrl_q;
    // Control flags are kept at 0 whenever the slot is empty
    if (flush) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else if (ex_ready && lu) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else if (ex_ready) begin
      ex_valid_d     = id_valid;
      ex_a_d         = fwd_a;
      ex_b_d         = fwd_b;
      ex_imm_d       = id_imm;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_valid & id_reg_write;
      ex_mem_read_d  = id_valid & id_mem_read;
      ex_ctrl_d      = id_ctrl;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ex_valid_q     <= 1'b0;
      ex_a_q         <= '0;
      ex_b_q         <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= 5'd0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_ctrl_q      <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_a_q         <= ex_a_d;
      ex_b_q         <= ex_b_d;
      ex_imm_q       <= ex_imm_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_ctrl_q      <= ex_ctrl_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_a         = ex_a_q;
  assign ex_b         = ex_b_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_ctrl      = ex_ctrl_q;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts bubbles actually inserted into EX; wraps naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (lu && ex_ready && !flush) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the ID/EX register.
module tb_id_ex_stage;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic clr, flush, id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic mem_reg_write, ex_ready;
  logic [4:0] id_rs, id_rt, id_rd, mem_rd;
  logic [DATA_W-1:0] id_imm, rf_a, rf_b, ex_result, mem_result;
  logic [CTRL_W-1:0] id_ctrl;
  logic id_ready, ex_valid, ex_reg_write, ex_mem_read;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
  logic [4:0] ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0] stall_cnt_s;

  // model of the ID/EX register contents
  logic m_valid, m_rw, m_mr;
  logic [DATA_W-1:0] m_a, m_b, m_imm;
  logic [4:0] m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  logic [31:0] m_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] cnt_before;

  id_ex_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clr(clr), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_a(rf_a), .rf_b(rf_b),
    .ex_result(ex_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt_s)
`endif
  );

`ifndef ID_EX_STALL_CNT_EN
  assign stall_cnt_s = m_cnt;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] fwd(input logic [4:0] r, input logic [DATA_W-1:0] rf);
    if (r == 5'd0) return '0;
    if (m_valid && m_rw && !m_mr && m_rd == r) return ex_result;
    if (mem_reg_write && mem_rd == r) return mem_result;
    return rf;
  endfunction

  // One clock: check id_ready, advance the model, then check registered outputs
  task automatic tick();
    logic lu;
    logic [DATA_W-1:0] fa, fb;
    #1;
    lu = id_valid && m_valid && m_mr && m_rw && (m_rd != 5'd0) &&
         ((id_use_rs && m_rd == id_rs) || (id_use_rt && m_rd == id_rt));
    chk("id_ready", {63'd0, id_ready}, {63'd0, ex_ready && !lu});
    fa = fwd(id_rs, rf_a);
    fb = fwd(id_rt, rf_b);
    @(posedge clk);
    if (clr) begin
      m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_a = '0; m_b = '0; m_imm = '0;
      m_rd = 5'd0; m_ctrl = '0; m_cnt = 32'd0;
    end else begin
      if (!flush && ex_ready && lu) m_cnt = m_cnt + 32'd1;
      if (flush || (ex_ready && lu)) begin
        m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0;
      end else if (ex_ready) begin
        m_valid = id_valid; m_a = fa; m_b = fb; m_imm = id_imm; m_rd = id_rd;
        m_rw = id_valid && id_reg_write; m_mr = id_valid && id_mem_read; m_ctrl = id_ctrl;
      end
    end
    @(negedge clk);
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
    chk("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m_rw});
    chk("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m_mr});
    if (m_valid) begin
      chk("ex_a", {32'd0, ex_a}, {32'd0, m_a});
      chk("ex_b", {32'd0, ex_b}, {32'd0, m_b});
      chk("ex_imm", {32'd0, ex_imm}, {32'd0, m_imm});
      chk("ex_rd", {59'd0, ex_rd}, {59'd0, m_rd});
      chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, m_ctrl});
    end
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_cnt", {32'd0, stall_cnt_s}, {32'd0, m_cnt});
`endif
  endtask

  task automatic idle();
    clr = 1'b0; flush = 1'b0; id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; mem_reg_write = 1'b0; ex_ready = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; mem_rd = 5'd0; id_imm = '0; rf_a = '0;
    rf_b = '0; ex_result = '0; mem_result = '0; id_ctrl = '0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
  endtask

  initial begin
    m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_a = '0; m_b = '0; m_imm = '0;
    m_rd = 5'd0; m_ctrl = '0; m_cnt = 32'd0;
    idle();
    clr = 1'b1;
    @(negedge clk);
    tick();
    tick();
    clr = 1'b0;
    tick();
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ex_a", {32'd0, ex_a}, 64'd0);
    chk("rst_ex_b", {32'd0, ex_b}, 64'd0);
    chk("rst_id_ready", {63'd0, id_ready}, 64'd1);

    // forwarding priority
    instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    instr(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0);
    ex_result = 32'h11; mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h22; rf_a = 32'h33;
    tick();
    chk("fwd_ex", {32'd0, ex_a}, 64'h11);
    tick();
    chk("fwd_mem", {32'd0, ex_a}, 64'h22);
    mem_reg_write = 1'b0;
    tick();
    chk("fwd_rf", {32'd0, ex_a}, 64'h33);
    id_rs = 5'd0;
    tick();
    chk("fwd_zero", {32'd0, ex_a}, 64'h0);

    // load-use: one bubble then MEM forward
    idle();
    instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    cnt_before = m_cnt;
    instr(5'd0, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    rf_b = 32'h1234;
    #1;
    chk("lu_ready_low", {63'd0, id_ready}, 64'd0);
    tick();
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    mem_rd = 5'd7; mem_reg_write = 1'b1; mem_result = 32'hDEAD;
    #1;
    chk("lu_ready_back", {63'd0, id_ready}, 64'd1);
    tick();
    chk("lu_fwd_b", {32'd0, ex_b}, 64'hDEAD);
    chk("lu_valid", {63'd0, ex_valid}, 64'd1);
`ifdef ID_EX_STALL_CNT_EN
    chk("lu_cnt", {32'd0, stall_cnt_s}, {32'd0, cnt_before + 32'd1});
`endif

    // load followed by non-user of rt: no stall
    idle();
    instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    instr(5'd0, 5'd7, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    chk("nouse_ready", {63'd0, id_ready}, 64'd1);
    tick();

    // EX backpressure holds, release captures once
    idle();
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd", {59'd0, ex_rd}, 64'd3);
      chk("hold_valid", {63'd0, ex_valid}, 64'd1);
    end
    ex_ready = 1'b1;
    tick();
    chk("release_rd", {59'd0, ex_rd}, 64'd9);
    id_valid = 1'b0;
    tick();
    chk("release_once", {63'd0, ex_valid}, 64'd0);

    // flush with a valid slot
    instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    flush = 1'b0;

    // clr in the middle of a load-use stall
    idle();
    instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    rf_a = 32'h55;
    tick();
    instr(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    ex_ready = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    chk("clr_valid", {63'd0, ex_valid}, 64'd0);
    chk("clr_a", {32'd0, ex_a}, 64'd0);
    chk("clr_rd", {59'd0, ex_rd}, 64'd0);
    chk("clr_rw", {63'd0, ex_reg_write}, 64'd0);
`ifdef ID_EX_STALL_CNT_EN
    chk("clr_cnt", {32'd0, stall_cnt_s}, 64'd0);
`endif
    clr = 1'b0;

    // randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      clr = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 8);
      ex_ready = ($urandom_range(0, 99) < 80);
      id_valid = ($urandom_range(0, 99) < 85);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7));
      id_use_rs = $urandom_range(0, 1); id_use_rt = $urandom_range(0, 1);
      id_reg_write = $urandom_range(0, 1); id_mem_read = ($urandom_range(0, 99) < 40);
      mem_reg_write = $urandom_range(0, 1);
      id_imm = $urandom; rf_a = $urandom; rf_b = $urandom;
      ex_result = $urandom; mem_result = $urandom; id_ctrl = CTRL_W'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
